// File: rtl/hx8352_bus_arbiter.sv
// Two-port arbiter and 8080-style CS/RS/WR strobe generator for the HX8352 LCD write bus, with locked bursts.
// Define HX8352_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module hx8352_bus_arbiter #(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_rs,
    input  logic [15:0] req0_data,
    input  logic        req0_lock,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_rs,
    input  logic [15:0] req1_data,
    input  logic        req1_lock,
    output logic        req1_ready,
    output logic        grant,
    output logic        busy,
    output logic        lcd_cs,
    output logic        lcd_wr,
    output logic        lcd_rd,
    output logic        lcd_rs,
    output logic [15:0] lcd_data
);
    typedef enum logic [2:0] {IDLE, SETUP, WR_LO, WR_HI, HOLD} state_t;

    localparam logic [7:0] LO_LOAD = 8'(WR_LOW_CYCLES - 1);
    localparam logic [7:0] HI_LOAD = 8'(WR_HIGH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       grant_nxt;
    logic       winner;
    logic       accept;
    logic       own_valid;
    logic       own_lock;

`ifdef HX8352_ARB_FIXED_PRIO_EN
    assign winner = !req0_valid;
`else
    logic last;
    // On a tie the port that did not own the bus last time wins.
    assign winner = (req0_valid && req1_valid) ? !last : req1_valid;
`endif

    assign own_valid = grant ? req1_valid : req0_valid;
    assign own_lock  = grant ? req1_lock  : req0_lock;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_nxt = winner;
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = WR_LO;
                cnt_nxt   = LO_LOAD;
            end
            WR_LO: begin
                if (cnt == 8'd0) begin
                    state_nxt = WR_HI;
                    cnt_nxt   = HI_LOAD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            WR_HI: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else if (!own_lock) begin
                    state_nxt = IDLE;
                end else if (own_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end else begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // A word offered as the lock drops is still taken, as the final one.
                if (own_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end else if (!own_lock) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            grant    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            grant <= grant_nxt;
            if (accept) begin
                lcd_rs   <= grant_nxt ? req1_rs   : req0_rs;
                lcd_data <= grant_nxt ? req1_data : req0_data;
            end
        end
    end

`ifndef HX8352_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (state != IDLE && state_nxt == IDLE) begin
            last <= grant;
        end
    end
`endif

    assign req0_ready = accept && !rst && !grant_nxt;
    assign req1_ready = accept && !rst && grant_nxt;
    assign busy       = (state != IDLE);
    assign lcd_cs     = (state == IDLE);
    assign lcd_wr     = (state != WR_LO);
    assign lcd_rd     = 1'b1;

endmodule

// File: tb/tb_hx8352_bus_arbiter.sv
// Bench for hx8352_bus_arbiter: burst-level arbitration model feeding a scoreboard checked by a bus monitor.
module tb_hx8352_bus_arbiter #(
    parameter int L = 2,
    parameter int H = 2
);
`ifdef HX8352_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic        rs;
        logic [15:0] data;
        logic        cont;
        int          gap;
    } item_t;

    typedef struct {
        int          port;
        logic        rs;
        logic [15:0] data;
        int          period;
        int          cs_hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, l0 = 1'b0, r0 = 1'b0;
    logic        v1 = 1'b0, l1 = 1'b0, r1 = 1'b0;
    logic [15:0] d0 = 16'd0, d1 = 16'd0;
    logic        req0_ready, req1_ready, grant, busy;
    logic        lcd_cs, lcd_wr, lcd_rd, lcd_rs;
    logic [15:0] lcd_data;

    item_t pq0[$], pq1[$], stg0[$], stg1[$];
    exp_t  expq[$];
    bit    have_ [2];
    int    m_last = 1;
    int    n_chk = 0;
    int    n_pass = 0;

    hx8352_bus_arbiter #(.WR_LOW_CYCLES(L), .WR_HIGH_CYCLES(H)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_rs(r0), .req0_data(d0), .req0_lock(l0), .req0_ready(req0_ready),
        .req1_valid(v1), .req1_rs(r1), .req1_data(d1), .req1_lock(l1), .req1_ready(req1_ready),
        .grant(grant), .busy(busy),
        .lcd_cs(lcd_cs), .lcd_wr(lcd_wr), .lcd_rd(lcd_rd), .lcd_rs(lcd_rs), .lcd_data(lcd_data)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic int qsize(input int p);
        return (p != 0) ? pq1.size() : pq0.size();
    endfunction

    function automatic item_t qhead(input int p);
        return (p != 0) ? pq1[0] : pq0[0];
    endfunction

    function automatic logic rdy(input int p);
        return (p != 0) ? req1_ready : req0_ready;
    endfunction

    function automatic int pending();
        return pq0.size() + pq1.size() + expq.size() + int'(have_[0]) + int'(have_[1]) + int'(busy);
    endfunction

    // Requester drivers: present the head item, hold lock for burst continuations, honour gaps.
    initial begin : drivers
        item_t cur [2];
        int    low_left [2];
        bit    pv [2];
        item_t dummy;
        have_[0] = 1'b0;
        have_[1] = 1'b0;
        low_left[0] = 0;
        low_left[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (!have_[p] && qsize(p) > 0) begin
                    cur[p]      = qhead(p);
                    have_[p]    = 1'b1;
                    low_left[p] = (cur[p].cont && cur[p].gap > 0) ? cur[p].gap + L + H : 0;
                end
                pv[p] = have_[p] && (low_left[p] == 0);
                if (low_left[p] > 0) low_left[p]--;
            end
            v0 = pv[0]; l0 = have_[0] && cur[0].cont; r0 = cur[0].rs; d0 = cur[0].data;
            v1 = pv[1]; l1 = have_[1] && cur[1].cont; r1 = cur[1].rs; d1 = cur[1].data;
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (have_[p] && pv[p] && rdy(p)) begin
                    if (p != 0) dummy = pq1.pop_front();
                    else        dummy = pq0.pop_front();
                    have_[p] = 1'b0;
                end
            end
        end
    end

    // Bus monitor: every completed WR pulse pops one expected word.
    initial begin : monitor
        bit          pw;
        bit          foreign;
        int          cyc, last_fall, period, wlo, cs_gap, cs_at_fall;
        logic [16:0] fall_bus;
        exp_t        e;
        pw = 1'b1; foreign = 1'b0; cyc = 0; last_fall = 0; period = 0;
        wlo = 0; cs_gap = 0; cs_at_fall = 0; fall_bus = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pw = 1'b1; wlo = 0; cs_gap = 0; foreign = 1'b0;
                continue;
            end
            if (busy && (grant ? req0_ready : req1_ready)) foreign = 1'b1;
            if (lcd_cs) cs_gap++;
            if (pw && !lcd_wr) begin
                period     = cyc - last_fall;
                last_fall  = cyc;
                fall_bus   = {lcd_rs, lcd_data};
                wlo        = 0;
                cs_at_fall = cs_gap;
                cs_gap     = 0;
            end
            if (!lcd_wr) wlo++;
            if (!pw && lcd_wr && !lcd_cs) begin
                chk("word_expected", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("grant", 32'(grant), 32'(e.port));
                    chk("bus_word", 32'({lcd_rs, lcd_data}), 32'({e.rs, e.data}));
                    chk("bus_at_wr_fall", 32'(fall_bus), 32'({e.rs, e.data}));
                    chk("wr_low_clks", 32'(wlo), 32'(L));
                    chk("foreign_ready", 32'(foreign), 32'd0);
                    if (e.period >= 0) begin
                        chk("word_period", 32'(period), 32'(e.period));
                        chk("cs_high_between", 32'(cs_at_fall), 32'(e.cs_hi));
                    end
                end
                foreign = 1'b0;
            end
            pw = lcd_wr;
        end
    end

    task automatic stage(input int p, input logic rs, input logic [15:0] d, input logic cont, input int gap);
        item_t it;
        it.rs = rs; it.data = d; it.cont = cont; it.gap = gap;
        if (p != 0) stg1.push_back(it);
        else        stg0.push_back(it);
    endtask

    // Reference model: whole bursts are granted one at a time; ties go to the non-last port.
    task automatic launch();
        int    i0, i1, pick;
        bit    first, more;
        item_t it;
        exp_t  e;
        i0 = 0; i1 = 0; first = 1'b1;
        while (i0 < stg0.size() || i1 < stg1.size()) begin
            if (i0 < stg0.size() && i1 < stg1.size()) pick = (FIXED || m_last != 0) ? 0 : 1;
            else pick = (i0 < stg0.size()) ? 0 : 1;
            more = 1'b1;
            while (more) begin
                if (pick != 0) begin it = stg1[i1]; i1++; end
                else           begin it = stg0[i0]; i0++; end
                e.port   = pick;
                e.rs     = it.rs;
                e.data   = it.data;
                e.period = first ? -1 : (it.cont ? 1 + L + H + it.gap : 2 + L + H);
                e.cs_hi  = it.cont ? 0 : 1;
                expq.push_back(e);
                first = 1'b0;
                if (pick != 0) more = (i1 < stg1.size()) && stg1[i1].cont;
                else           more = (i0 < stg0.size()) && stg0[i0].cont;
            end
            m_last = pick;
        end
        @(negedge clk);
        foreach (stg0[i]) pq0.push_back(stg0[i]);
        foreach (stg1[i]) pq1.push_back(stg1[i]);
        stg0.delete();
        stg1.delete();
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (pending() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(pending()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_cs", 32'(lcd_cs), 32'd1);
        chk("rst_wr", 32'(lcd_wr), 32'd1);
        chk("rst_rd", 32'(lcd_rd), 32'd1);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_last = 1;
    endtask

    initial begin : main
        int          k, nb, len, busy_seen;
        logic [31:0] cs_pat, wr_pat, cs_exp, wr_exp;
        item_t       it;
        do_reset();

        // Isolated command word: strobe shape relative to the accept cycle.
        stage(0, 1'b0, 16'h0022, 1'b0, 0);
        launch();
        k = 0;
        while (!req0_ready && k < 50) begin @(negedge clk); k++; end
        chk("iso_ready_seen", 32'(req0_ready), 32'd1);
        cs_pat = '0; wr_pat = '0; cs_exp = '0; wr_exp = '0;
        for (int i = 1; i <= L + H + 2; i++) begin
            @(negedge clk);
            cs_pat[i] = lcd_cs;
            wr_pat[i] = lcd_wr;
            cs_exp[i] = (i > 1 + L + H);
            wr_exp[i] = !(i >= 2 && i <= 1 + L);
        end
        chk("iso_cs_shape", cs_pat, cs_exp);
        chk("iso_wr_shape", wr_pat, wr_exp);
        wait_drain();

        // Ties straight after reset, then another tie.
        do_reset();
        stage(0, 1'b0, 16'h1111, 1'b0, 0);
        stage(1, 1'b1, 16'h2222, 1'b0, 0);
        launch();
        wait_drain();
        stage(0, 1'b1, 16'h3333, 1'b0, 0);
        stage(1, 1'b0, 16'h4444, 1'b0, 0);
        launch();
        wait_drain();
        stage(0, 1'b0, 16'h5555, 1'b0, 0);
        launch();
        wait_drain();

        // Locked pixel burst on port 1 with port 0 contending.
        for (int w = 0; w < 4; w++) stage(1, 1'b1, 16'hF800, w > 0, 0);
        stage(0, 1'b0, 16'h002C, 1'b0, 0);
        launch();
        wait_drain();

        // Locked burst with a 7-clock hole in the middle.
        for (int w = 0; w < 4; w++) stage(0, 1'b1, 16'hA000 + 16'(w), w > 0, (w == 2) ? 7 : 0);
        launch();
        wait_drain();

        // Reset during WR low: word is dropped, not replayed.
        @(negedge clk);
        it.rs = 1'b1; it.data = 16'hBEEF; it.cont = 1'b0; it.gap = 0;
        pq0.push_back(it);
        k = 0;
        while (lcd_wr && k < 50) begin @(negedge clk); k++; end
        chk("mid_wr_low_seen", 32'(lcd_wr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_last = 1;
        @(negedge clk);
        chk("mid_cs", 32'(lcd_cs), 32'd1);
        chk("mid_wr", 32'(lcd_wr), 32'd1);
        chk("mid_data", 32'({lcd_rs, lcd_data}), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_seen += int'(busy);
        end
        chk("mid_no_reissue", 32'(busy_seen), 32'd0);

        // Randomised bursts from both ports.
        for (int s = 0; s < 30; s++) begin
            for (int p = 0; p < 2; p++) begin
                nb = $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    len = $urandom_range(1, 4);
                    for (int w = 0; w < len; w++)
                        stage(p, 1'($urandom_range(0, 1)), 16'($urandom), w > 0,
                              (w > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
                end
            end
            launch();
            wait_drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
